rice_bus_arbiter: RTL and testbench

//  N:1 arbiter sharing one downstream rice bus slave between MASTERS upstream requesters.

---
 rtl/rice_bus_pkg.sv | 14 +
 rtl/rice_bus_arbiter_id_fifo.sv | 56 +++++
 rtl/rice_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_rice_bus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rice_bus_pkg.sv
// Shared types and helpers for the rice bus N:1 arbiter.
package rice_bus_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Grant ID width; never zero so a 1-bit ID still exists for degenerate cases.
  function automatic int unsigned id_width(input int unsigned masters);
    return (masters > 1) ? $clog2(masters) : 1;
  endfunction

endpackage

// File: rtl/rice_bus_arbiter_id_fifo.sv
// In-order FIFO of granted master IDs; the head selects the response destination.
module rice_bus_arbiter_id_fifo
  import rice_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= advance(wr_ptr);
      if (do_pop)  rd_ptr <= advance(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/rice_bus_arbiter.sv
// Round-robin N:1 rice bus arbiter with grant lock and in-order response routing.
module rice_bus_arbiter
  import rice_bus_pkg::*;
#(
  parameter int unsigned MASTERS         = 2,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [MASTERS-1:0]                i_request_valid,
  output logic [MASTERS-1:0]                o_request_ready,
  input  logic [MASTERS-1:0]                i_write,
  input  logic [MASTERS*ADDRESS_WIDTH-1:0]  i_address,
  input  logic [MASTERS*DATA_WIDTH/8-1:0]   i_strobe,
  input  logic [MASTERS*DATA_WIDTH-1:0]     i_write_data,
  output logic [MASTERS-1:0]                o_response_valid,
  input  logic [MASTERS-1:0]                i_response_ready,
  output logic [DATA_WIDTH-1:0]             o_read_data,
  output logic                              o_error,
  output logic                              o_request_valid,
  input  logic                              i_request_ready,
  output logic                              o_write,
  output logic [ADDRESS_WIDTH-1:0]          o_address,
  output logic [DATA_WIDTH/8-1:0]           o_strobe,
  output logic [DATA_WIDTH-1:0]             o_write_data,
  input  logic                              i_response_valid,
  output logic                              o_response_ready,
  input  logic [DATA_WIDTH-1:0]             i_read_data,
  input  logic                              i_error
);

  localparam int unsigned ID_W   = id_width(MASTERS);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [STRB_W-1:0]        strobe;
    logic [DATA_WIDTH-1:0]    data;
  } request_t;

  arb_state_e state, state_next;
  id_t        pointer, grant_q, search, grant, head_id;
  logic       fifo_full, fifo_empty, req_fire, rsp_fire;
  request_t   sel;

  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    search = pointer;
    for (int unsigned k = 0; k < MASTERS; k++) begin
      idx = (32'(pointer) + k) % MASTERS;
      if (!found && i_request_valid[idx]) begin
        found  = 1'b1;
        search = id_t'(idx);
      end
    end
  end

  assign grant = (state == ARB_LOCKED) ? grant_q : search;

  always_comb begin
    sel.write   = i_write[grant];
    sel.address = i_address[grant * ADDRESS_WIDTH +: ADDRESS_WIDTH];
    sel.strobe  = i_strobe[grant * STRB_W +: STRB_W];
    sel.data    = i_write_data[grant * DATA_WIDTH +: DATA_WIDTH];
  end

  assign o_write         = sel.write;
  assign o_address       = sel.address;
  assign o_strobe        = sel.strobe;
  assign o_write_data    = sel.data;
  assign o_request_valid = i_request_valid[grant] && !fifo_full;
  assign req_fire        = o_request_valid && i_request_ready;

  always_comb begin
    o_request_ready        = '0;
    o_request_ready[grant] = i_request_ready && !fifo_full;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:   if (o_request_valid && !i_request_ready) state_next = ARB_LOCKED;
      ARB_LOCKED: if (req_fire) state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // grant_q tracks the live grant while idle so it already holds the right ID on lock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ARB_IDLE;
      pointer <= '0;
      grant_q <= '0;
    end else begin
      state <= state_next;
      if (state == ARB_IDLE) grant_q <= grant;
      if (req_fire) pointer <= (grant == id_t'(MASTERS - 1)) ? '0 : grant + 1'b1;
    end
  end

  rice_bus_arbiter_id_fifo #(
    .DEPTH(MAX_OUTSTANDING),
    .WIDTH(ID_W)
  ) u_id_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .push   (req_fire),
    .push_id(grant),
    .pop    (rsp_fire),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head_id)
  );

  always_comb begin
    o_response_valid = '0;
    o_response_ready = 1'b0;
    if (!fifo_empty) begin
      o_response_valid[head_id] = i_response_valid;
      o_response_ready          = i_response_ready[head_id];
    end
  end

  assign rsp_fire    = i_response_valid && o_response_ready;
  assign o_read_data = i_read_data;
  assign o_error     = i_error;

  // A response with nothing outstanding has no destination and is dropped.
  no_orphan_response: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_response_valid && fifo_empty));

endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Directed self-checking bench for rice_bus_arbiter (2 masters, 4 outstanding).
module tb_rice_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready_m;
  logic [1:0]  write = '0;
  logic [63:0] address = '0;
  logic [7:0]  strobe = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  rsp_valid_m;
  logic [1:0]  rsp_ready_m = '0;
  logic [31:0] rdata;
  logic        err;
  logic        dn_req_valid;
  logic        dn_req_ready = 1'b0;
  logic        dn_write;
  logic [31:0] dn_addr;
  logic [3:0]  dn_strb;
  logic [31:0] dn_wdata;
  logic        dn_rsp_valid = 1'b0;
  logic        dn_rsp_ready;
  logic [31:0] dn_rdata = '0;
  logic        dn_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rice_bus_arbiter #(
    .MASTERS(2),
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_request_valid (req_valid),
    .o_request_ready (req_ready_m),
    .i_write         (write),
    .i_address       (address),
    .i_strobe        (strobe),
    .i_write_data    (wdata),
    .o_response_valid(rsp_valid_m),
    .i_response_ready(rsp_ready_m),
    .o_read_data     (rdata),
    .o_error         (err),
    .o_request_valid (dn_req_valid),
    .i_request_ready (dn_req_ready),
    .o_write         (dn_write),
    .o_address       (dn_addr),
    .o_strobe        (dn_strb),
    .o_write_data    (dn_wdata),
    .i_response_valid(dn_rsp_valid),
    .o_response_ready(dn_rsp_ready),
    .i_read_data     (dn_rdata),
    .i_error         (dn_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rv [3];
    exp_rv = '{2'b01, 2'b10, 2'b01};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_req_valid", 64'(dn_req_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready_m), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("rst_rsp_ready", 64'(dn_rsp_ready), 64'd0);

    // Single master 0 write, same-cycle downstream visibility
    write = 2'b01; address = {32'h0, 32'h1000}; wdata = {32'h0, 32'hDEADBEEF};
    strobe = 8'h3F; req_valid = 2'b01; dn_req_ready = 1'b1;
    #1;
    check("m0_req_valid", 64'(dn_req_valid), 64'd1);
    check("m0_addr", 64'(dn_addr), 64'h1000);
    check("m0_write", 64'(dn_write), 64'd1);
    check("m0_wdata", 64'(dn_wdata), 64'hDEADBEEF);
    check("m0_strobe", 64'(dn_strb), 64'hF);
    check("m0_req_ready", 64'(req_ready_m), 64'b01);
    tick();
    req_valid = '0; dn_rsp_valid = 1'b1; dn_rdata = 32'h1234; dn_err = 1'b1; rsp_ready_m = 2'b01;
    #1;
    check("m0_rsp_valid", 64'(rsp_valid_m), 64'b01);
    check("m0_rsp_ready", 64'(dn_rsp_ready), 64'd1);
    check("m0_rdata", 64'(rdata), 64'h1234);
    check("m0_err", 64'(err), 64'd1);
    tick();
    dn_rsp_valid = 1'b0; rsp_ready_m = 2'b11;
    #1;
    check("empty_rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("empty_rsp_ready", 64'(dn_rsp_ready), 64'd0);

    // Both masters request every cycle: alternating grants until the FIFO fills
    rst = 1'b1; tick(); rst = 1'b0;
    dn_err = 1'b0; write = '0; address = {32'h3000, 32'h2000}; req_valid = 2'b11; dn_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_addr", 64'(dn_addr), (i % 2 == 1) ? 64'h3000 : 64'h2000);
      check("rr_ready", 64'(req_ready_m), (i % 2 == 1) ? 64'b10 : 64'b01);
      tick();
    end
    #1;
    check("full_req_valid", 64'(dn_req_valid), 64'd0);
    check("full_req_ready", 64'(req_ready_m), 64'd0);
    dn_rsp_valid = 1'b1; rsp_ready_m = 2'b11; dn_rdata = 32'hA0;
    #1;
    check("full_rsp_head", 64'(rsp_valid_m), 64'b01);
    check("full_no_bypass", 64'(dn_req_valid), 64'd0);
    tick();
    #1;
    check("pushpop_rsp_head", 64'(rsp_valid_m), 64'b10);
    check("pushpop_req_valid", 64'(dn_req_valid), 64'd1);
    check("pushpop_addr", 64'(dn_addr), 64'h2000);
    tick();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drain_rsp_valid", 64'(rsp_valid_m), 64'(exp_rv[i]));
      tick();
    end
    dn_rsp_valid = 1'b0;
    #1;
    check("drained_rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("drained_rsp_ready", 64'(dn_rsp_ready), 64'd0);

    // Lock: master 1 stalled by downstream while master 0 joins
    rst = 1'b1; tick(); rst = 1'b0;
    address = {32'h5000, 32'h2000}; req_valid = 2'b10; dn_req_ready = 1'b0;
    #1;
    check("lock_req_valid", 64'(dn_req_valid), 64'd1);
    check("lock_addr", 64'(dn_addr), 64'h5000);
    check("lock_ready", 64'(req_ready_m), 64'd0);
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("locked_addr", 64'(dn_addr), 64'h5000);
      check("locked_ready", 64'(req_ready_m), 64'd0);
      tick();
    end
    dn_req_ready = 1'b1;
    #1;
    check("unlock_addr", 64'(dn_addr), 64'h5000);
    check("unlock_ready", 64'(req_ready_m), 64'b10);
    tick();
    #1;
    check("after_lock_addr", 64'(dn_addr), 64'h2000);
    check("after_lock_ready", 64'(req_ready_m), 64'b01);
    req_valid = '0; dn_req_ready = 1'b0;

    // Response stalled by its destination master
    dn_rsp_valid = 1'b1; rsp_ready_m = 2'b01;
    #1;
    check("stall_rsp_valid", 64'(rsp_valid_m), 64'b10);
    check("stall_rsp_ready", 64'(dn_rsp_ready), 64'd0);
    tick();
    #1;
    check("stall_hold", 64'(rsp_valid_m), 64'b10);

    // Reset mid-burst clears outstanding state
    req_valid = 2'b11; dn_req_ready = 1'b1;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = '0; dn_rsp_valid = 1'b0; rsp_ready_m = 2'b11;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("midrst_rsp_ready", 64'(dn_rsp_ready), 64'd0);
    check("midrst_req_valid", 64'(dn_req_valid), 64'd0);
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("refill_ready", 64'(req_ready_m), 64'b01);
      tick();
    end
    #1;
    check("refill_full", 64'(req_ready_m), 64'd0);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
